// File: rtl/fmap_tx_pkg.sv
// fmap_tx_pkg: shared types and constants for the fmap_stream_tx slice.
//   tx_state_e    - transmitter FSM states
//   tx_flags_t    - registered control outputs, kept together so the whole
//                   control word can be observed as one struct
//   FLAGS_RESET   - value of the control word in reset and in IDLE
//   cnt_width()   - bits needed to index 0..n-1 (at least 1)
package fmap_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_FILL,
    ST_HSYNC,
    ST_WAIT,
    ST_SEND,
    ST_GAPW
  } tx_state_e;

  typedef struct packed {
    logic vsync;
    logic hsync;
    logic reuse;
    logic valid;
    logic ready;
    logic busy;
    logic done;
  } tx_flags_t;

  localparam tx_state_e ST_RESET    = ST_IDLE;
  localparam tx_flags_t FLAGS_RESET = '0;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_row_ram.sv
// fmap_row_ram: one-row sample buffer. Simple dual-port memory, one write
// port and one read port with a single registered read stage. No reset, so
// it maps onto block RAM.
//   clk               clock
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr     read request; rd_data is valid the following cycle
//   rd_data           registered read data (holds when rd_en=0)
module fmap_row_ram #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 3584,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx: buffers one feature-map row (SIZE*CHANNEL words) from an
// upstream ready/valid source and re-emits it as a vsync/hsync/reuse/valid/
// tdata frame stream for a group line-buffer chain.
//
// Handshake: a word is transferred on every rising clock edge at which
// o_ready and i_valid are both high; o_ready is only high in FILL, and the
// downstream side has no back-pressure (o_valid is never stalled).
//
// Ports:
//   i_sclk, i_rst_n   clock, asynchronous active-low reset
//   i_start           frame start, sampled only in IDLE
//   i_valid, i_tdata  upstream sample stream; o_ready upstream ready
//   o_vsync           frame marker, VS_LEN cycles
//   o_hsync           one-cycle row start
//   o_reuse           replayed row marker (on hsync and valid cycles)
//   o_valid, o_tdata  row samples; o_tdata is 0 whenever o_valid is 0
//   o_busy, o_done    frame in progress / one-cycle frame end pulse
//
// Build option: define FMAP_TX_REUSE_EN to emit every row twice, the second
// copy flagged with o_reuse. Without it o_reuse is constant 0.
module fmap_stream_tx
  import fmap_tx_pkg::*;
#(
  parameter int         WIDTH_D = 27,
  parameter int         SIZE    = 28,
  parameter int         CHANNEL = 128,
  parameter int         PADWAIT = 21,
  parameter logic [3:0] GAP     = 4'd0,
  parameter int         VS_LEN  = 4
) (
  input  logic               i_sclk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_valid,
  input  logic [WIDTH_D-1:0] i_tdata,
  output logic               o_ready,
  output logic               o_vsync,
  output logic               o_hsync,
  output logic               o_reuse,
  output logic               o_valid,
  output logic [WIDTH_D-1:0] o_tdata,
  output logic               o_busy,
  output logic               o_done
);

  localparam int ROW_WORDS = SIZE * CHANNEL;
  localparam int AW        = cnt_width(ROW_WORDS);
  localparam int RW        = cnt_width(SIZE);
  localparam int GAP_I     = int'(GAP);
  localparam int CNT_MAX   = (VS_LEN > PADWAIT) ? ((VS_LEN > GAP_I) ? VS_LEN : GAP_I)
                                                : ((PADWAIT > GAP_I) ? PADWAIT : GAP_I);
  localparam int CW        = cnt_width(CNT_MAX);

  localparam logic [AW-1:0] LAST_WORD = AW'(ROW_WORDS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(SIZE - 1);
  localparam logic [CW-1:0] VS_LAST   = CW'(VS_LEN - 1);
  localparam logic [CW-1:0] PAD_LAST  = CW'((PADWAIT > 0) ? PADWAIT - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_I > 0) ? GAP_I - 1 : 0);

  tx_state_e          state;
  tx_flags_t          flags;
  logic [CW-1:0]      cnt;
  logic [AW-1:0]      wr_cnt;
  logic [AW-1:0]      rd_cnt;
  logic [RW-1:0]      row_cnt;
`ifdef FMAP_TX_REUSE_EN
  logic               reuse_flag;
`endif

  logic               send_next;
  logic               emit_done;
  logic               wr_en;
  logic [WIDTH_D-1:0] rd_q;

  // send_next: the next cycle carries a sample. It doubles as the RAM read
  // enable, so the word addressed now lands on the output with o_valid.
  // rd_cnt is the address being fetched; it wraps to 0 after the last word,
  // so rd_cnt==0 inside SEND marks the final sample of the emission.
  always_comb begin
    send_next = 1'b0;
    case (state)
      ST_HSYNC: send_next = (PADWAIT == 0);
      ST_WAIT:  send_next = (cnt == PAD_LAST);
      ST_SEND:  send_next = (rd_cnt != '0);
      default:  send_next = 1'b0;
    endcase
  end

  assign emit_done = ((state == ST_SEND) && (rd_cnt == '0) && (GAP_I == 0)) ||
                     ((state == ST_GAPW) && (cnt == GAP_LAST));
  assign wr_en     = (state == ST_FILL) && i_valid;

  fmap_row_ram #(
    .WIDTH (WIDTH_D),
    .DEPTH (ROW_WORDS),
    .AW    (AW)
  ) u_row_ram (
    .clk     (i_sclk),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt),
    .wr_data (i_tdata),
    .rd_en   (send_next),
    .rd_addr (rd_cnt),
    .rd_data (rd_q)
  );

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_RESET;
      flags   <= FLAGS_RESET;
      cnt     <= '0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      row_cnt <= '0;
`ifdef FMAP_TX_REUSE_EN
      reuse_flag <= 1'b0;
`endif
    end else begin
      flags.vsync <= 1'b0;
      flags.hsync <= 1'b0;
      flags.ready <= 1'b0;
      flags.done  <= 1'b0;
      flags.valid <= send_next;
`ifdef FMAP_TX_REUSE_EN
      flags.reuse <= reuse_flag & send_next;
`else
      flags.reuse <= 1'b0;
`endif
      if (send_next) rd_cnt <= (rd_cnt == LAST_WORD) ? '0 : rd_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state       <= ST_VSYNC;
            flags.vsync <= 1'b1;
            flags.busy  <= 1'b1;
            cnt         <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            row_cnt     <= '0;
`ifdef FMAP_TX_REUSE_EN
            reuse_flag  <= 1'b0;
`endif
          end
        end
        ST_VSYNC: begin
          if (cnt == VS_LAST) begin
            state       <= ST_FILL;
            flags.ready <= 1'b1;
          end else begin
            cnt         <= cnt + 1'b1;
            flags.vsync <= 1'b1;
          end
        end
        ST_FILL: begin
          flags.ready <= 1'b1;
          if (i_valid) begin
            if (wr_cnt == LAST_WORD) begin
              wr_cnt      <= '0;
              state       <= ST_HSYNC;
              flags.ready <= 1'b0;
              flags.hsync <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        ST_HSYNC: begin
          cnt   <= '0;
          state <= (PADWAIT == 0) ? ST_SEND : ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == PAD_LAST) state <= ST_SEND;
          else                 cnt   <= cnt + 1'b1;
        end
        ST_SEND: begin
          if (rd_cnt == '0) begin
            cnt <= '0;
            if (GAP_I != 0) state <= ST_GAPW;
          end
        end
        ST_GAPW: begin
          if (cnt != GAP_LAST) cnt <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase

      // End of one emission: replay, next row, or frame end.
      if (emit_done) begin
`ifdef FMAP_TX_REUSE_EN
        reuse_flag <= ~reuse_flag;
        if (!reuse_flag) begin
          state       <= ST_HSYNC;
          flags.hsync <= 1'b1;
          flags.reuse <= 1'b1;
        end else
`endif
        if (row_cnt != ROW_LAST) begin
          row_cnt     <= row_cnt + 1'b1;
          state       <= ST_FILL;
          flags.ready <= 1'b1;
        end else begin
          state      <= ST_IDLE;
          flags.done <= 1'b1;
          flags.busy <= 1'b0;
        end
      end
    end
  end

  assign o_ready = flags.ready;
  assign o_vsync = flags.vsync;
  assign o_hsync = flags.hsync;
  assign o_reuse = flags.reuse;
  assign o_valid = flags.valid;
  assign o_busy  = flags.busy;
  assign o_done  = flags.done;
  // RAM read register gated by the registered valid: stale buffer data never
  // leaks out between samples or while reset holds o_valid low.
  assign o_tdata = flags.valid ? rd_q : '0;

endmodule
